// File: rtl/burst_ram_tester.sv
// burst_ram_tester: post-calibration self test of the burst RAM. Writes
// pattern(a) = seed ^ a to every word in bursts, reads back, flags the first failure.
module burst_ram_tester #(
  parameter int unsigned                BURST_RAM_DEPTH_BITWIDTH = 4,
  parameter int unsigned                BURST_COUNT              = 4,
  parameter int unsigned                DATA_BITWIDTH            = 32,
  parameter logic [DATA_BITWIDTH-1:0]   PATTERN_SEED             = 32'hA5A5_0000,
  parameter int unsigned                TIMEOUT_CYCLES           = 1024
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst_n,
  input  logic                                br_init_calib,
  input  logic                                br_busy,
  output logic                                br_cmd,
  output logic                                br_cmd_en,
  output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [DATA_BITWIDTH-1:0]            br_wr_data,
  input  logic [DATA_BITWIDTH-1:0]            br_rd_data,
  input  logic                                br_rd_data_valid,
  output logic                                done,
  output logic                                fail,
  output logic                                timeout,
  output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] fail_addr
);

  localparam int unsigned AW         = BURST_RAM_DEPTH_BITWIDTH;
  localparam int unsigned DW         = DATA_BITWIDTH;
  localparam int unsigned IW         = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
  localparam int unsigned TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned DEPTH      = 1 << AW;
  localparam int unsigned LAST_BURST = DEPTH - BURST_COUNT;

  typedef enum logic [2:0] {
    S_WAIT_CALIB,
    S_WR_CMD,
    S_WR_DATA,
    S_RD_CMD,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [IW-1:0]   r_idx;
  logic [TW-1:0]   r_timer;
  logic            r_cmd;
  logic            r_cmd_en;
  logic [AW-1:0]   r_br_addr;
  logic [DW-1:0]   r_wr_data;
  logic            r_done;
  logic            r_fail;
  logic            r_timeout;
  logic [AW-1:0]   r_fail_addr;

  logic [AW-1:0]   w_word_addr;
  logic [AW-1:0]   w_next_base;
  logic            w_last_word;
  logic            w_last_burst;
  logic            w_timer_expired;
  logic            w_rd_mismatch;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return PATTERN_SEED ^ DW'(a);
  endfunction

  assign w_word_addr     = r_addr + AW'(r_idx);
  assign w_next_base     = r_addr + AW'(BURST_COUNT);
  assign w_last_word     = (r_idx == IW'(BURST_COUNT - 1));
  assign w_last_burst    = (r_addr == AW'(LAST_BURST));
  assign w_timer_expired = (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_rd_mismatch   = (br_rd_data != pattern(w_word_addr));

  // Single sequencer: all outputs are registered and change with the state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_WAIT_CALIB;
      r_addr      <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_cmd       <= 1'b0;
      r_cmd_en    <= 1'b0;
      r_br_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_fail_addr <= '0;
    end else begin
      r_cmd_en  <= 1'b0;
      r_wr_data <= '0;
      case (r_state)
        S_WAIT_CALIB: begin
          r_addr <= '0;
          r_idx  <= '0;
          if (br_init_calib) r_state <= S_WR_CMD;
        end
        S_WR_CMD: begin
          if (!br_busy) begin
            r_cmd_en  <= 1'b1;
            r_cmd     <= 1'b1;
            r_br_addr <= r_addr;
            r_wr_data <= pattern(r_addr);
            if (BURST_COUNT == 1) begin
              r_addr  <= w_next_base;
              r_state <= w_last_burst ? S_RD_CMD : S_WR_CMD;
            end else begin
              r_idx   <= IW'(1);
              r_state <= S_WR_DATA;
            end
          end
        end
        S_WR_DATA: begin
          r_wr_data <= pattern(w_word_addr);
          if (w_last_word) begin
            r_idx   <= '0;
            r_addr  <= w_next_base;
            r_state <= w_last_burst ? S_RD_CMD : S_WR_CMD;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_RD_CMD: begin
          if (!br_busy) begin
            r_cmd_en  <= 1'b1;
            r_cmd     <= 1'b0;
            r_br_addr <= r_addr;
            r_idx     <= '0;
            r_timer   <= '0;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (br_rd_data_valid) begin
            r_timer <= '0;
            // Only the first failure is recorded; the pass still runs to the end.
            if (w_rd_mismatch && !r_fail) begin
              r_fail      <= 1'b1;
              r_fail_addr <= w_word_addr;
            end
            if (w_last_word) begin
              r_idx  <= '0;
              r_addr <= w_next_base;
              if (w_last_burst) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_RD_CMD;
              end
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else if (w_timer_expired) begin
            r_fail    <= 1'b1;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            if (!r_fail) r_fail_addr <= w_word_addr;
            r_state   <= S_DONE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
        end
        default: r_state <= S_WAIT_CALIB;
      endcase
    end
  end

  assign br_cmd     = r_cmd;
  assign br_cmd_en  = r_cmd_en;
  assign br_addr    = r_br_addr;
  assign br_wr_data = r_wr_data;
  assign done       = r_done;
  assign fail       = r_fail;
  assign timeout    = r_timeout;
  assign fail_addr  = r_fail_addr;

endmodule

// File: tb/tb_burst_ram_tester.sv
// tb_burst_ram_tester: burst RAM model with busy/gap/corrupt/stall knobs and a
// scoreboard of the expected command sequence, write words and final verdict.
module tb_burst_ram_tester;

  localparam int unsigned AW    = 4;
  localparam int unsigned BC    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned TO    = 16;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned B     = DEPTH / BC;
  localparam int unsigned LAT   = B * (2 * BC + 2) + 1;
  localparam logic [31:0] SEED  = 32'hA5A5_0000;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          br_init_calib = 1'b0;
  logic          br_busy = 1'b0;
  logic          br_cmd;
  logic          br_cmd_en;
  logic [AW-1:0] br_addr;
  logic [DW-1:0] br_wr_data;
  logic [DW-1:0] br_rd_data = '0;
  logic          br_rd_data_valid = 1'b0;
  logic          done;
  logic          fail;
  logic          timeout;
  logic [AW-1:0] fail_addr;

  burst_ram_tester #(
    .BURST_RAM_DEPTH_BITWIDTH(AW),
    .BURST_COUNT             (BC),
    .DATA_BITWIDTH           (DW),
    .PATTERN_SEED            (SEED),
    .TIMEOUT_CYCLES          (TO)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .br_init_calib   (br_init_calib),
    .br_busy         (br_busy),
    .br_cmd          (br_cmd),
    .br_cmd_en       (br_cmd_en),
    .br_addr         (br_addr),
    .br_wr_data      (br_wr_data),
    .br_rd_data      (br_rd_data),
    .br_rd_data_valid(br_rd_data_valid),
    .done            (done),
    .fail            (fail),
    .timeout         (timeout),
    .fail_addr       (fail_addr)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Knobs for the RAM model
  int          busy_len    = 0;   // 0 none, >0 fixed hold per command, -1 random
  logic [15:0] corrupt     = '0;  // words whose read-back gets bit 0 flipped
  int          stall_burst = -1;  // read burst index that never returns data
  bit          gaps        = 1'b0;

  // RAM model state
  logic [31:0] mem [DEPTH];
  int cmd_k, rd_burst_n, busy_hold, stall_cyc;
  int wr_base, wr_idx, wr_left;
  int rd_base, rd_idx, rd_left, rd_wait;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int next_busy();
    if (busy_len < 0) return int'($urandom_range(0, 10));
    return busy_len;
  endfunction

  function automatic int first_bad(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  always @(posedge sys_clk) cyc++;

  // RAM model: drives busy/read data on the falling edge, checks commands and write words.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      cmd_k = 0; rd_burst_n = 0; wr_left = 0; rd_left = 0; rd_wait = 0;
      busy_hold = next_busy();
      br_busy = 1'b0; br_rd_data_valid = 1'b0; br_rd_data = '0;
    end else begin
      if (br_cmd_en) begin
        check("cmd_while_busy", 32'(br_busy), 32'd0);
        check("cmd_dir", 32'(br_cmd), 32'(cmd_k < int'(B)));
        check("cmd_addr", 32'(br_addr), 32'((cmd_k % int'(B)) * int'(BC)));
        if (br_cmd) begin
          wr_base = int'(br_addr); wr_idx = 0; wr_left = BC;
        end else begin
          if (rd_burst_n != stall_burst) begin
            rd_base = int'(br_addr); rd_idx = 0; rd_left = BC; rd_wait = 1;
          end else begin
            stall_cyc = cyc;
          end
          rd_burst_n++;
        end
        cmd_k++;
        busy_hold = next_busy();
      end else if (busy_hold > 0) begin
        busy_hold--;
      end
      br_busy = (busy_hold > 0);

      if (wr_left > 0) begin
        check("wr_data", br_wr_data, SEED ^ 32'((wr_base + wr_idx) % DEPTH));
        mem[(wr_base + wr_idx) % DEPTH] = br_wr_data;
        wr_idx++; wr_left--;
      end else begin
        check("wr_data_idle", br_wr_data, 32'd0);
      end

      if (rd_left > 0) begin
        if (rd_wait > 0) begin
          rd_wait--;
          br_rd_data_valid = 1'b0;
        end else begin
          int a;
          a = (rd_base + rd_idx) % DEPTH;
          br_rd_data_valid = 1'b1;
          br_rd_data = mem[a] ^ {31'b0, corrupt[a]};
          rd_idx++; rd_left--;
          rd_wait = gaps ? int'($urandom_range(0, 2)) : 0;
        end
      end else if (gaps && cmd_k < int'(B) && $urandom_range(0, 3) == 0) begin
        br_rd_data_valid = 1'b1;      // stray strobe outside any read burst
        br_rd_data = $urandom;
      end else begin
        br_rd_data_valid = 1'b0;
      end
    end
  end

  task automatic set_knobs(input int bl, input logic [15:0] cm, input int st, input bit gp);
    busy_len = bl; corrupt = cm; stall_burst = st; gaps = gp;
  endtask

  task automatic run_case(input int calib_wait, input bit lat_chk);
    int n, t0, nc, exp_fa, exp_cmds;
    bit exp_fail, exp_to;
    sys_rst_n = 1'b0; br_init_calib = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    nc = 0;
    repeat (calib_wait) begin
      @(negedge sys_clk);
      if (br_cmd_en || done || fail) nc++;
    end
    check("pre_calib_activity", 32'(nc), 32'd0);
    br_init_calib = 1'b1; t0 = cyc;
    n = 0;
    while (!done && n < 3000) begin @(negedge sys_clk); n++; end
    check("done_seen", 32'(done), 32'd1);
    if (lat_chk) check("done_latency", 32'(cyc - t0), 32'(LAT));
    exp_fail = (corrupt != 0) || (stall_burst >= 0);
    exp_to   = (stall_burst >= 0);
    exp_fa   = (corrupt != 0) ? first_bad(corrupt) : (exp_to ? stall_burst * int'(BC) : 0);
    exp_cmds = exp_to ? int'(B) + stall_burst + 1 : 2 * int'(B);
    if (exp_to) check("timeout_cycles", 32'(cyc - stall_cyc), 32'(TO));
    check("fail", 32'(fail), 32'(exp_fail));
    check("timeout", 32'(timeout), 32'(exp_to));
    check("fail_addr", 32'(fail_addr), 32'(exp_fa));
    check("cmd_count", 32'(cmd_k), 32'(exp_cmds));
    br_init_calib = 1'b0;
    repeat (8) @(negedge sys_clk);
    check("done_sticky", 32'(done), 32'd1);
    check("fail_sticky", 32'(fail), 32'(exp_fail));
    check("no_restart", 32'(cmd_k), 32'(exp_cmds));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_en"}, 32'(br_cmd_en), 32'd0);
    check({tag, "_cmd"}, 32'(br_cmd), 32'd0);
    check({tag, "_addr"}, 32'(br_addr), 32'd0);
    check({tag, "_wr_data"}, br_wr_data, 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_fail"}, 32'(fail), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_fail_addr"}, 32'(fail_addr), 32'd0);
  endtask

  initial begin
    int n, nw, kind;
    logic [15:0] m;

    set_knobs(0, 16'h0000, -1, 1'b0);  run_case(0, 1'b1);    // ideal pass
    set_knobs(10, 16'h0000, -1, 1'b0); run_case(0, 1'b0);    // busy 10 per command
    set_knobs(0, 16'h0040, -1, 1'b0);  run_case(0, 1'b0);    // word 6 corrupted
    set_knobs(0, 16'h0000, 1, 1'b0);   run_case(0, 1'b0);    // 2nd read burst stalls

    // Async reset out of DONE with every flag set
    @(posedge sys_clk); #2 sys_rst_n = 1'b0; #1;
    check_all_zero("rst_from_done");

    set_knobs(0, 16'h0000, -1, 1'b0);  run_case(200, 1'b1);  // late calibration

    // Async reset in the middle of the second write burst, then a clean rerun
    set_knobs(0, 16'h0000, -1, 1'b0);
    sys_rst_n = 1'b0; br_init_calib = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    br_init_calib = 1'b1;
    n = 0; nw = 0;
    while (nw < 2 && n < 200) begin
      @(negedge sys_clk); n++;
      if (br_cmd_en && br_cmd) nw++;
    end
    check("mid_wr_cmd_seen", 32'(nw), 32'd2);
    @(posedge sys_clk); #1;
    check("mid_wr_word", br_wr_data, SEED ^ 32'd5);
    #1 sys_rst_n = 1'b0; #1;
    check_all_zero("rst_mid_write");
    run_case(0, 1'b1);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      m = '0;
      kind = int'($urandom_range(0, 2));
      for (int j = 0; j < kind; j++) m[$urandom_range(0, 15)] = 1'b1;
      set_knobs(($urandom_range(0, 1) == 1) ? -1 : 0, m, -1, 1'($urandom_range(0, 1)));
      run_case(int'($urandom_range(0, 20)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
